// File: rtl/bsg_cgol_pkg.sv
// Shared types and width helpers for the Game-of-Life board controller.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eLOAD = 2'd1,
    eRUN  = 2'd2,
    eDONE = 2'd3
  } cgol_state_e;

  function automatic int cgol_cells_f(input int width);
    return width * width;
  endfunction

  function automatic int cgol_ctr_width_f(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// Loadable down-counter for the generation budget; the load value is clamped
// to max_val_p and decrement stops at zero.
module bsg_cgol_frame_counter #(
  parameter int width_p   = 10,
  parameter int max_val_p = 1023
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic               one_o
);

  localparam logic [width_p-1:0] MaxVal = max_val_p[width_p-1:0];
  localparam logic [width_p-1:0] One    = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign one_o  = (count_q == One);

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Board controller: loads a seed into the cell array, steps it a requested
// number of generations, then offers the resulting board to the consumer.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p     = 8,
  parameter int max_game_length_p = 1023,
  localparam int N = cgol_cells_f(board_width_p),
  localparam int G = cgol_ctr_width_f(max_game_length_p)
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         v_i,
  input  logic [N-1:0] data_i,
  input  logic [G-1:0] frames_i,
  output logic         ready_o,
  output logic         en_o,
  output logic         update_o,
  output logic [N-1:0] update_val_o,
  input  logic [N-1:0] board_i,
  output logic         v_o,
  output logic [N-1:0] data_o,
  input  logic         yumi_i
);

  cgol_state_e state_q, state_d;
  logic [N-1:0] seed_q, seed_d;
  logic         ctr_load, ctr_dec, ctr_zero, ctr_one;

  bsg_cgol_frame_counter #(
    .width_p  (G),
    .max_val_p(max_game_length_p)
  ) u_frame_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (ctr_load),
    .load_val_i(frames_i),
    .dec_i     (ctr_dec),
    .zero_o    (ctr_zero),
    .one_o     (ctr_one)
  );

  // Outputs decode from state_q only; inputs affect next state, never outputs.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ready_o  = 1'b0;
    en_o     = 1'b0;
    update_o = 1'b0;
    v_o      = 1'b0;
    unique case (state_q)
      eIDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          seed_d   = data_i;
          ctr_load = 1'b1;
          state_d  = eLOAD;
        end
      end
      eLOAD: begin
        update_o = 1'b1;
        state_d  = ctr_zero ? eDONE : eRUN;
      end
      eRUN: begin
        en_o    = 1'b1;
        ctr_dec = 1'b1;
        if (ctr_one) begin
          state_d = eDONE;
        end
      end
      eDONE: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_d = eIDLE;
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
    end
  end

  assign update_val_o = seed_q;
  // The array is frozen in DONE (no en/update), so the live board is the result.
  assign data_o       = board_i;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Bench for bsg_cgol_ctrl on a 4x4 board with a behavioural cell array
// (dead cells beyond the edges) and a second instance for budget clamping.
module tb_bsg_cgol_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [9:0]  frames_i = '0;
  logic        ready_o, en_o, update_o, v_o;
  logic [15:0] update_val_o, data_o;
  logic [15:0] cells = '0;
  logic        yumi_i = 1'b0;

  logic        s_v_i = 1'b0;
  logic [15:0] s_data_i = '0;
  logic [2:0]  s_frames_i = '0;
  logic        s_ready_o, s_en_o, s_update_o, s_v_o;
  logic [15:0] s_update_val_o, s_data_o;
  logic [15:0] s_board_i = '0;
  logic        s_yumi_i = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          en;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_cgol_ctrl #(.board_width_p(4), .max_game_length_p(1023)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
    .frames_i(frames_i), .ready_o(ready_o), .en_o(en_o), .update_o(update_o),
    .update_val_o(update_val_o), .board_i(cells), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i)
  );

  bsg_cgol_ctrl #(.board_width_p(4), .max_game_length_p(5)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(s_v_i), .data_i(s_data_i),
    .frames_i(s_frames_i), .ready_o(s_ready_o), .en_o(s_en_o),
    .update_o(s_update_o), .update_val_o(s_update_val_o), .board_i(s_board_i),
    .v_o(s_v_o), .data_o(s_data_o), .yumi_i(s_yumi_i)
  );

  function automatic logic [15:0] life_step(input logic [15:0] b);
    logic [15:0] nb;
    nb = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 4 &&
                (c + dc) >= 0 && (c + dc) < 4) begin
              if (b[(r + dr) * 4 + (c + dc)]) cnt++;
            end
          end
        end
        nb[r * 4 + c] = (cnt == 3) || (b[r * 4 + c] && cnt == 2);
      end
    end
    return nb;
  endfunction

  // Cell array: contents are not touched by the controller reset.
  always @(posedge clk) begin
    if (update_o) cells <= update_val_o;
    else if (en_o) cells <= life_step(cells);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int   acc_cyc, en_cnt, upd_cnt;
    logic v_prev;
    exp_t e;
    acc_cyc = 0; en_cnt = 0; upd_cnt = 0; v_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        v_prev = 1'b0;
      end else begin
        check("en_upd_exclusive", {31'd0, en_o & update_o}, 0);
        check("ready_v_exclusive", {31'd0, ready_o & v_o}, 0);
        if (yumi_i) check("yumi_legal", {31'd0, v_o}, 1);
        if (v_i && ready_o) begin
          acc_cyc = cyc; en_cnt = 0; upd_cnt = 0;
        end
        if (en_o) en_cnt++;
        if (update_o) upd_cnt++;
        if (v_o && !v_prev) begin
          check("sb_has_entry", sb_q.size(), (sb_q.size() == 0) ? 1 : sb_q.size());
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("data_o", {16'd0, data_o}, {16'd0, e.data});
            check("latency", cyc - acc_cyc, e.lat);
            check("en_cycles", en_cnt, e.en);
            check("update_pulses", upd_cnt, 1);
          end
        end
        v_prev = v_o;
      end
    end
  end

  task automatic start_game(input logic [15:0] seed, input logic [9:0] fr,
                            input logic [15:0] exp_d, input bit push);
    int t;
    t = 0;
    while (!ready_o && t < 100) begin @(negedge clk); t++; end
    check("ready_before_start", {31'd0, ready_o}, 1);
    @(posedge clk); #1;
    v_i = 1'b1; data_i = seed; frames_i = fr;
    if (push) sb_q.push_back('{exp_d, int'(fr) + 2, int'(fr)});
    @(posedge clk); #1;
    v_i = 1'b0; data_i = '0; frames_i = '0;
  endtask

  task automatic wait_v(input int bound);
    int t;
    t = 0;
    while (!v_o && t < bound) begin @(negedge clk); t++; end
    check("v_o_arrives", {31'd0, v_o}, 1);
  endtask

  task automatic take_result();
    @(posedge clk); #1; yumi_i = 1'b1;
    @(posedge clk); #1; yumi_i = 1'b0;
    @(negedge clk);
    check("ready_after_yumi", {31'd0, ready_o}, 1);
    check("v_low_after_yumi", {31'd0, v_o}, 0);
  endtask

  initial begin
    int t, en_seen;
    #1;
    check("rst_ready_o", {31'd0, ready_o}, 1);
    check("rst_en_o", {31'd0, en_o}, 0);
    check("rst_update_o", {31'd0, update_o}, 0);
    check("rst_v_o", {31'd0, v_o}, 0);
    check("rst_update_val_o", {16'd0, update_val_o}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Blinker, one and two generations
    start_game(16'h0070, 10'd1, 16'h0222, 1'b1); wait_v(50); take_result();
    start_game(16'h0070, 10'd2, 16'h0070, 1'b1); wait_v(50); take_result();
    // Block still life, zero and five generations
    start_game(16'h0033, 10'd0, 16'h0033, 1'b1); wait_v(50); take_result();
    start_game(16'h0033, 10'd5, 16'h0033, 1'b1); wait_v(50); take_result();

    // Backpressure: hold the result while v_i pulses are offered
    start_game(16'h0070, 10'd1, 16'h0222, 1'b1); wait_v(50);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      v_i = i[0]; data_i = 16'hffff; frames_i = 10'd3;
      @(negedge clk);
      check("bp_v_o", {31'd0, v_o}, 1);
      check("bp_data_o", {16'd0, data_o}, 32'h0222);
      check("bp_ready_o", {31'd0, ready_o}, 0);
    end
    @(posedge clk); #1; v_i = 1'b0; data_i = '0; frames_i = '0;
    take_result();

    // Reset during RUN
    start_game(16'h0070, 10'd20, 16'h0000, 1'b0);
    t = 0;
    while (!en_o && t < 20) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check("midrun_en_o", {31'd0, en_o}, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_ready_o", {31'd0, ready_o}, 1);
    check("midrst_en_o", {31'd0, en_o}, 0);
    check("midrst_update_o", {31'd0, update_o}, 0);
    check("midrst_v_o", {31'd0, v_o}, 0);
    check("midrst_update_val_o", {16'd0, update_val_o}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    start_game(16'h0070, 10'd1, 16'h0222, 1'b1); wait_v(50); take_result();

    // Budget clamp on the max_game_length_p=5 instance
    @(posedge clk); #1;
    s_v_i = 1'b1; s_data_i = 16'h0070; s_frames_i = 3'd7;
    @(posedge clk); #1;
    s_v_i = 1'b0;
    en_seen = 0; t = 0;
    while (!s_v_o && t < 50) begin
      @(negedge clk);
      if (s_en_o) en_seen++;
      t++;
    end
    check("sat_v_o", {31'd0, s_v_o}, 1);
    check("sat_en_cycles", en_seen, 5);
    @(posedge clk); #1; s_yumi_i = 1'b1;
    @(posedge clk); #1; s_yumi_i = 1'b0;
    @(negedge clk);
    check("sat_ready_after_yumi", {31'd0, s_ready_o}, 1);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
